// File: rtl/synthetic_mul_seq.sv
// Sequential chunked multiplier: OP_W operands cast to 8/16/32/64 bits, B consumed CHUNK_W bits per cycle.
// Define SYNTH_MUL_FLAGS_EN to add the registered out_ovf (CF/OF) flag.
module synthetic_mul_seq #(
  parameter int OP_W    = 32,
  parameter int CHUNK_W = 16,
  parameter int TAG_W   = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_signed,
  input  logic [1:0]          in_size,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*OP_W-1:0]   out_res,
  output logic [TAG_W-1:0]    out_tag
`ifdef SYNTH_MUL_FLAGS_EN
  ,
  output logic                out_ovf
`endif
);

  localparam int RES_W   = 2 * OP_W;
  localparam int MAX_NCH = OP_W / CHUNK_W;
  localparam int CNT_W   = $clog2(MAX_NCH + 1);

  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;

  state_t              state_reg;
  logic [RES_W-1:0]    a_sh_reg;
  logic [OP_W-1:0]     b_sh_reg;
  logic [RES_W-1:0]    acc_reg;
  logic [CNT_W-1:0]    idx_reg;
  logic [CNT_W-1:0]    last_reg;
  logic                neg_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic [RES_W-1:0]    out_res_reg;
  logic [TAG_W-1:0]    out_tag_reg;

  // Per-size cast of the operands and chunk count; sizes wider than OP_W clamp to OP_W.
  logic [OP_W-1:0]     a_ext [4];
  logic [OP_W-1:0]     b_ext [4];
  logic [CNT_W-1:0]    nch_tab [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_size
      localparam int SW  = ((8 << gi) < OP_W) ? (8 << gi) : OP_W;
      localparam int NCH = (SW + CHUNK_W - 1) / CHUNK_W;
      if (SW == OP_W) begin : g_full
        assign a_ext[gi] = in_a;
        assign b_ext[gi] = in_b;
      end else begin : g_part
        assign a_ext[gi] = {{(OP_W-SW){in_signed & in_a[SW-1]}}, in_a[SW-1:0]};
        assign b_ext[gi] = {{(OP_W-SW){in_signed & in_b[SW-1]}}, in_b[SW-1:0]};
      end
      assign nch_tab[gi] = CNT_W'(NCH);
    end
  endgenerate

  logic [OP_W-1:0]  a_sel, b_sel, mag_a, mag_b;
  logic             sign_a, sign_b;
  logic [RES_W-1:0] partial, acc_sum, fix_res;

  assign a_sel   = a_ext[in_size];
  assign b_sel   = b_ext[in_size];
  assign sign_a  = in_signed & a_sel[OP_W-1];
  assign sign_b  = in_signed & b_sel[OP_W-1];
  assign mag_a   = sign_a ? (~a_sel + OP_W'(1)) : a_sel;
  assign mag_b   = sign_b ? (~b_sel + OP_W'(1)) : b_sel;

  // a_sh_reg carries |A| pre-shifted to the weight of the current B chunk.
  assign partial = a_sh_reg * {{(RES_W-CHUNK_W){1'b0}}, b_sh_reg[CHUNK_W-1:0]};
  assign acc_sum = acc_reg + partial;
  assign fix_res = neg_reg ? (~acc_reg + RES_W'(1)) : acc_reg;

`ifdef SYNTH_MUL_FLAGS_EN
  logic [1:0] size_reg;
  logic       signed_reg;
  logic       out_ovf_reg;
  logic [3:0] ovf_tab;

  generate
    for (gi = 0; gi < 4; gi++) begin : g_ovf
      localparam int SW = ((8 << gi) < OP_W) ? (8 << gi) : OP_W;
      assign ovf_tab[gi] = signed_reg ? (fix_res[2*SW-1:SW] != {SW{fix_res[SW-1]}})
                                      : (|fix_res[2*SW-1:SW]);
    end
  endgenerate

  assign out_ovf = out_ovf_reg;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      acc_reg       <= '0;
      idx_reg       <= '0;
      last_reg      <= '0;
      neg_reg       <= 1'b0;
      tag_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_res_reg   <= '0;
      out_tag_reg   <= '0;
`ifdef SYNTH_MUL_FLAGS_EN
      size_reg      <= '0;
      signed_reg    <= 1'b0;
      out_ovf_reg   <= 1'b0;
`endif
    end else if (flush) begin
      state_reg     <= IDLE;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
`ifdef SYNTH_MUL_FLAGS_EN
      out_ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_sh_reg     <= {{OP_W{1'b0}}, mag_a};
            b_sh_reg     <= mag_b;
            acc_reg      <= '0;
            idx_reg      <= '0;
            last_reg     <= nch_tab[in_size] - CNT_W'(1);
            neg_reg      <= sign_a ^ sign_b;
            tag_reg      <= in_tag;
            in_ready_reg <= 1'b0;
            state_reg    <= MUL;
`ifdef SYNTH_MUL_FLAGS_EN
            size_reg     <= in_size;
            signed_reg   <= in_signed;
`endif
          end
        end
        MUL: begin
          acc_reg  <= acc_sum;
          a_sh_reg <= a_sh_reg << CHUNK_W;
          b_sh_reg <= b_sh_reg >> CHUNK_W;
          idx_reg  <= idx_reg + CNT_W'(1);
          if (idx_reg == last_reg) state_reg <= FIX;
        end
        FIX: begin
          out_res_reg   <= fix_res;
          out_tag_reg   <= tag_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= DONE;
`ifdef SYNTH_MUL_FLAGS_EN
          out_ovf_reg   <= ovf_tab[size_reg];
`endif
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
`ifdef SYNTH_MUL_FLAGS_EN
            out_ovf_reg   <= 1'b0;
`endif
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_res   = out_res_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_synthetic_mul_seq.sv
// Self-checking bench for synthetic_mul_seq (default parameters) with a arithmetic reference model.
module tb_synthetic_mul_seq;
  localparam int OP_W  = 32;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic              in_signed;
  logic [1:0]        in_size;
  logic [OP_W-1:0]   in_a, in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*OP_W-1:0] out_res;
  logic [TAG_W-1:0]  out_tag;
  logic              out_ovf;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  synthetic_mul_seq #(.OP_W(OP_W), .CHUNK_W(16), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_signed (in_signed),
    .in_size   (in_size),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag)
`ifdef SYNTH_MUL_FLAGS_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

`ifndef SYNTH_MUL_FLAGS_EN
  assign out_ovf = 1'b0;
`endif

  // Reference: exact integer product of the cast operands, flag from range check, latency from chunk count.
  function automatic void model(input bit sg, input logic [1:0] sz, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] res,
                                output logic ovf, output int lat);
    int s;
    logic signed [127:0] ea, eb, p, lim;
    s = 8 << sz;
    if (s > OP_W) s = OP_W;
    ea = '0;
    eb = '0;
    for (int i = 0; i < s; i++) begin
      ea[i] = a[i];
      eb[i] = b[i];
    end
    if (sg && a[s-1]) ea = ea - (128'sd1 << s);
    if (sg && b[s-1]) eb = eb - (128'sd1 << s);
    p   = ea * eb;
    res = p[63:0];
    lim = 128'sd1 << s;
    if (sg) ovf = (p >= (lim >>> 1)) || (p < -(lim >>> 1));
    else    ovf = (p >= lim);
    lat = (s + 15) / 16 + 1;
  endfunction

  // Issues one request, waits (bounded) for out_valid, then completes the output handshake.
  task automatic run_op(input bit sg, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input int hold, output int lat,
                        output logic [63:0] res, output logic [3:0] t, output logic ovf);
    in_signed = sg;
    in_size   = sz;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_tag   = 4'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_res;
    t   = out_tag;
    ovf = out_ovf;
    repeat (hold) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_signed = 1'b0; in_size = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    #12;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_res !== 64'd0 || out_tag !== 4'd0)
      $display("FAIL reset_out_res_tag: got %h/%h expected 0/0", out_res, out_tag);
    else pass_cnt++;
`ifdef SYNTH_MUL_FLAGS_EN
    total_cnt++;
    if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b expected 0", out_ovf);
    else pass_cnt++;
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          sg;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] r;
    int          lat;
    bit          ovf;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[7];
    int lat;
    logic [63:0] res;
    logic [3:0] t;
    logic ovf;
    vecs[0] = '{1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 3, 1'b1};
    vecs[1] = '{1'b1, 2'b00, 32'h0000_0080, 32'h0000_007F, 64'hFFFF_FFFF_FFFF_C080, 2, 1'b1};
    vecs[2] = '{1'b1, 2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_0000_0001, 2, 1'b0};
    vecs[3] = '{1'b0, 2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 2, 1'b1};
    vecs[4] = '{1'b1, 2'b11, 32'h0000_0003, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFF7, 3, 1'b0};
    vecs[5] = '{1'b0, 2'b00, 32'hABCD_12F0, 32'h55AA_0011, 64'h0000_0000_0000_0FF0, 2, 1'b1};
    vecs[6] = '{1'b1, 2'b00, 32'h1234_5603, 32'h0000_00FE, 64'hFFFF_FFFF_FFFF_FFFA, 2, 1'b0};
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].sg, vecs[i].sz, vecs[i].a, vecs[i].b, 4'(i + 1), i % 3, lat, res, t, ovf);
      $display("directed %0d: sg=%0d sz=%0d a=%h b=%h res=%h tag=%h lat=%0d ovf=%b",
               i, vecs[i].sg, vecs[i].sz, vecs[i].a, vecs[i].b, res, t, lat, ovf);
      total_cnt++;
      if (res !== vecs[i].r) $display("FAIL directed_res[%0d]: got %h expected %h", i, res, vecs[i].r);
      else pass_cnt++;
      total_cnt++;
      if (lat != vecs[i].lat) $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, vecs[i].lat);
      else pass_cnt++;
      total_cnt++;
      if (t !== 4'(i + 1)) $display("FAIL directed_tag[%0d]: got %h expected %h", i, t, 4'(i + 1));
      else pass_cnt++;
`ifdef SYNTH_MUL_FLAGS_EN
      total_cnt++;
      if (ovf !== vecs[i].ovf) $display("FAIL directed_ovf[%0d]: got %b expected %b", i, ovf, vecs[i].ovf);
      else pass_cnt++;
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [63:0] exp_res, snap_res, res;
    logic [3:0]  snap_tag, t;
    logic        exp_ovf, ovf;
    int          exp_lat, lat, waited;
    a = $urandom; b = $urandom;
    model(1'b1, 2'b10, a, b, exp_res, exp_ovf, exp_lat);
    in_signed = 1'b1; in_size = 2'b10; in_a = a; in_b = b; in_tag = 4'h9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    snap_res = out_res;
    snap_tag = out_tag;
    total_cnt++;
    if (snap_res !== exp_res || snap_tag !== 4'h9)
      $display("FAIL bp_result: got %h/%h expected %h/9", snap_res, snap_tag, exp_res);
    else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total_cnt++;
      if (out_res !== snap_res || out_tag !== snap_tag || in_ready !== 1'b0 || out_valid !== 1'b1)
        $display("FAIL bp_hold[%0d]: got res=%h tag=%h in_ready=%b out_valid=%b expected res=%h tag=%h in_ready=0 out_valid=1",
                 c, out_res, out_tag, in_ready, out_valid, snap_res, snap_tag);
      else pass_cnt++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    else pass_cnt++;
    $display("backpressure: res=%h tag=%h held 5 cycles", snap_res, snap_tag);
    a = $urandom; b = $urandom;
    model(1'b0, 2'b01, a, b, exp_res, exp_ovf, exp_lat);
    run_op(1'b0, 2'b01, a, b, 4'hA, 0, lat, res, t, ovf);
    $display("back_to_back: a=%h b=%h res=%h tag=%h lat=%0d", a, b, res, t, lat);
    total_cnt++;
    if (res !== exp_res || t !== 4'hA || lat != exp_lat)
      $display("FAIL bp_next: got res=%h tag=%h lat=%0d expected res=%h tag=a lat=%0d", res, t, lat, exp_res, exp_lat);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    bit seen;
    int lat;
    logic [63:0] res;
    logic [3:0] t;
    logic ovf;
    in_signed = 1'b0; in_size = 2'b10; in_a = $urandom; in_b = $urandom; in_tag = 4'h3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen) $display("FAIL flush_no_result: got out_valid=1 expected 0");
    else pass_cnt++;
    $display("flush in MUL: dropped, in_ready=%b", in_ready);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flush_idle_reject: got in_ready=%b expected 1", in_ready);
    else pass_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (seen) $display("FAIL flush_idle_no_result: got out_valid=1 expected 0");
    else pass_cnt++;
    run_op(1'b1, 2'b01, 32'h0000_7FFF, 32'h0000_0002, 4'h6, 1, lat, res, t, ovf);
    $display("after flush: res=%h tag=%h lat=%0d ovf=%b", res, t, lat, ovf);
    total_cnt++;
    if (res !== 64'h0000_0000_0000_FFFE || t !== 4'h6 || lat != 2)
      $display("FAIL flush_next: got res=%h tag=%h lat=%0d expected res=000000000000fffe tag=6 lat=2", res, t, lat);
    else pass_cnt++;
`ifdef SYNTH_MUL_FLAGS_EN
    total_cnt++;
    if (ovf !== 1'b1) $display("FAIL flush_next_ovf: got %b expected 1", ovf);
    else pass_cnt++;
`endif
  endtask

  task automatic test_async_reset();
    int lat;
    logic [63:0] res;
    logic [3:0] t;
    logic ovf;
    in_signed = 1'b0; in_size = 2'b10; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_tag = 4'hC; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_res !== 64'd0 || out_tag !== 4'd0)
      $display("FAIL async_reset: got in_ready=%b out_valid=%b res=%h tag=%h expected 1/0/0/0",
               in_ready, out_valid, out_res, out_tag);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL async_reset_hold: got out_valid=%b expected 0", out_valid);
    else pass_cnt++;
    rstn = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 2'b10, 32'h0000_0003, 32'hFFFF_FFFD, 4'h5, 0, lat, res, t, ovf);
    $display("after reset: res=%h tag=%h lat=%0d ovf=%b", res, t, lat, ovf);
    total_cnt++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFF7 || t !== 4'h5 || lat != 3)
      $display("FAIL reset_next: got res=%h tag=%h lat=%0d expected res=fffffffffffffff7 tag=5 lat=3", res, t, lat);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit          sg;
    logic [1:0]  sz;
    logic [31:0] a, b;
    logic [3:0]  tag, t;
    logic [63:0] exp_res, res;
    logic        exp_ovf, ovf;
    int          exp_lat, lat;
    for (int i = 0; i < 40; i++) begin
      sg  = 1'($urandom);
      sz  = 2'($urandom);
      a   = $urandom;
      b   = $urandom;
      tag = 4'($urandom);
      if (i % 8 == 0) a = 32'h8000_0000 >> (24 - 8 * (sz == 2'b11 ? 3 : int'(sz)));
      model(sg, sz, a, b, exp_res, exp_ovf, exp_lat);
      run_op(sg, sz, a, b, tag, int'($urandom_range(0, 3)), lat, res, t, ovf);
      $display("random %0d: sg=%0d sz=%0d a=%h b=%h res=%h tag=%h lat=%0d ovf=%b",
               i, sg, sz, a, b, res, t, lat, ovf);
      total_cnt++;
      if (res !== exp_res || t !== tag || lat != exp_lat)
        $display("FAIL random[%0d]: got res=%h tag=%h lat=%0d expected res=%h tag=%h lat=%0d",
                 i, res, t, lat, exp_res, tag, exp_lat);
      else pass_cnt++;
`ifdef SYNTH_MUL_FLAGS_EN
      total_cnt++;
      if (ovf !== exp_ovf) $display("FAIL random_ovf[%0d]: got %b expected %b", i, ovf, exp_ovf);
      else pass_cnt++;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
